// File: rtl/lc3_mem_master.sv
// LC3 memory-side initiator. It arbitrates between fetch and data requests,
// holds each memory strobe until complete, and aborts stalled accesses with a watchdog.
module lc3_mem_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    // core side
    input  logic        fetch_req,
    input  logic [15:0] fetch_pc,
    output logic        fetch_ack,
    output logic [15:0] fetch_instr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        data_ack,
    output logic [15:0] data_rdata,
    output logic        busy,
    output logic        timeout_err,
    // instruction memory side
    output logic        instrmem_rd,
    output logic [15:0] pc,
    input  logic [15:0] Instr_dout,
    input  logic        complete_instr,
    // data memory side
    output logic        Data_rd,
    output logic        Data_wr,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    input  logic [15:0] Data_dout,
    input  logic        complete_data
);

    typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;

    // The watchdog counter only needs to reach TIMEOUT-1.
    localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wd_cnt;
    logic          wd_expire;

    // Set on the last allowed strobe cycle. A complete on that same edge still wins.
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    // NOTE: every register here is assigned with <= so that all of them
    // sample the pre-edge values. This keeps the block order-independent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            busy        <= 1'b0;
            fetch_ack   <= 1'b0;
            fetch_instr <= 16'h0000;
            data_ack    <= 1'b0;
            data_rdata  <= 16'h0000;
            timeout_err <= 1'b0;
            instrmem_rd <= 1'b0;
            pc          <= 16'h0000;
            Data_rd     <= 1'b0;
            Data_wr     <= 1'b0;
            Data_addr   <= 16'h0000;
            Data_din    <= 16'h0000;
        end else begin
            fetch_ack   <= 1'b0;
            data_ack    <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    // During its own ack cycle, a requester's still-high req is stale.
                    if (data_req && !data_ack) begin
                        Data_addr <= data_addr;
                        wd_cnt    <= '0;
                        busy      <= 1'b1;
                        if (data_we) begin
                            state    <= DWRITE;
                            Data_din <= data_wdata;
                            Data_wr  <= 1'b1;
                        end else begin
                            state    <= DREAD;
                            Data_rd  <= 1'b1;
                        end
                    end else if (fetch_req && !fetch_ack) begin
                        state       <= FETCH;
                        pc          <= fetch_pc;
                        instrmem_rd <= 1'b1;
                        wd_cnt      <= '0;
                        busy        <= 1'b1;
                    end
                end

                FETCH: begin
                    if (complete_instr || wd_expire) begin
                        fetch_instr <= complete_instr ? Instr_dout : 16'h0000;
                        timeout_err <= !complete_instr;
                        fetch_ack   <= 1'b1;
                        instrmem_rd <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end

                DREAD: begin
                    if (complete_data || wd_expire) begin
                        data_rdata  <= complete_data ? Data_dout : 16'h0000;
                        timeout_err <= !complete_data;
                        data_ack    <= 1'b1;
                        Data_rd     <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end

                DWRITE: begin
                    if (complete_data || wd_expire) begin
                        timeout_err <= !complete_data;
                        data_ack    <= 1'b1;
                        Data_wr     <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end

                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    instrmem_rd <= 1'b0;
                    Data_rd     <= 1'b0;
                    Data_wr     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_master.sv
// Directed bench for lc3_mem_master. A transaction-level model is checked on every
// cycle, and literal expectations pin the key scenarios.
module tb_lc3_mem_master;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_pc;
    logic        fetch_ack;
    logic [15:0] fetch_instr;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        busy;
    logic        timeout_err;
    logic        instrmem_rd;
    logic [15:0] pc;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        Data_rd;
    logic        Data_wr;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;

    lc3_mem_master #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_req      (fetch_req),
        .fetch_pc       (fetch_pc),
        .fetch_ack      (fetch_ack),
        .fetch_instr    (fetch_instr),
        .data_req       (data_req),
        .data_we        (data_we),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_ack       (data_ack),
        .data_rdata     (data_rdata),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .instrmem_rd    (instrmem_rd),
        .pc             (pc),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .Data_rd        (Data_rd),
        .Data_wr        (Data_wr),
        .Data_addr      (Data_addr),
        .Data_din       (Data_din),
        .Data_dout      (Data_dout),
        .complete_data  (complete_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: at most one outstanding access, aged in strobe cycles.
    typedef enum {K_FETCH, K_LOAD, K_STORE} kind_e;
    bit          m_active;
    kind_e       m_kind;
    logic [15:0] m_addr, m_wdata;
    int          m_age;
    logic        m_fack, m_dack, m_terr;
    logic [15:0] m_finstr, m_drdata;

    always @(posedge clk or negedge reset) begin : model
        logic pf, pd;
        bit   done;
        if (!reset) begin
            m_active = 0; m_kind = K_FETCH; m_addr = 0; m_wdata = 0; m_age = 0;
            m_fack = 0; m_dack = 0; m_terr = 0; m_finstr = 0; m_drdata = 0;
        end else begin
            pf = m_fack;
            pd = m_dack;
            m_fack = 0; m_dack = 0; m_terr = 0;
            if (m_active) begin
                m_age++;
                done = (m_kind == K_FETCH) ? complete_instr : complete_data;
                if (done || m_age == TO) begin
                    m_active = 0;
                    m_terr   = !done;
                    if (m_kind == K_FETCH) begin
                        m_fack   = 1;
                        m_finstr = done ? Instr_dout : 16'h0000;
                    end else begin
                        m_dack = 1;
                        if (m_kind == K_LOAD) m_drdata = done ? Data_dout : 16'h0000;
                    end
                end
            end else if (data_req && !pd) begin
                m_active = 1; m_age = 0;
                m_kind   = data_we ? K_STORE : K_LOAD;
                m_addr   = data_addr;
                m_wdata  = data_wdata;
            end else if (fetch_req && !pf) begin
                m_active = 1; m_age = 0;
                m_kind   = K_FETCH;
                m_addr   = fetch_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_active);
            check("instrmem_rd", instrmem_rd, m_active && m_kind == K_FETCH);
            check("Data_rd", Data_rd, m_active && m_kind == K_LOAD);
            check("Data_wr", Data_wr, m_active && m_kind == K_STORE);
            check("fetch_ack", fetch_ack, m_fack);
            check("data_ack", data_ack, m_dack);
            check("timeout_err", timeout_err, m_terr);
            check("fetch_instr", fetch_instr, m_finstr);
            check("data_rdata", data_rdata, m_drdata);
            if (m_active && m_kind == K_FETCH) check("pc", pc, m_addr);
            if (m_active && m_kind != K_FETCH) check("Data_addr", Data_addr, m_addr);
            if (m_active && m_kind == K_STORE) check("Data_din", Data_din, m_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int lat, cyc;
        fetch_req = 0; fetch_pc = 0; data_req = 0; data_we = 0;
        data_addr = 0; data_wdata = 0; Instr_dout = 0; complete_instr = 0;
        Data_dout = 0; complete_data = 0;
        reset = 1;
        #1 reset = 0;
        #1 cmp_en = 1;
        step();
        step();
        check("reset busy", busy, 0);
        check("reset pc", pc, 0);
        check("reset Data_addr", Data_addr, 0);
        reset = 1;
        step();

        // Zero-wait fetch: the ack appears two edges after the request is raised.
        fetch_req = 1; fetch_pc = 16'h3000;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            lat++;
            if (fetch_ack) break;
            if (instrmem_rd && !complete_instr) begin
                check("zw fetch pc", pc, 16'h3000);
                complete_instr = 1; Instr_dout = 16'h1261;
            end
        end
        complete_instr = 0;
        check("zw fetch latency", lat, 2);
        check("zw fetch_instr", fetch_instr, 16'h1261);
        check("zw strobe dropped", instrmem_rd, 0);
        step();
        check("ack-cycle req ignored", busy, 0);
        fetch_req = 0;
        step();

        // Reset asserted mid-load clears all outputs asynchronously.
        data_req = 1; data_we = 0; data_addr = 16'h1234;
        step();
        check("pre-reset Data_rd", Data_rd, 1);
        check("pre-reset Data_addr", Data_addr, 16'h1234);
        #2 reset = 0;
        #1;
        check("async reset Data_rd", Data_rd, 0);
        check("async reset Data_addr", Data_addr, 0);
        check("async reset fetch_instr", fetch_instr, 0);
        check("async reset busy", busy, 0);
        data_req = 0;
        @(posedge clk);
        #1 reset = 1;
        step();
        check("post-reset busy", busy, 0);

        // Simultaneous requests: the load wins, then the fetch follows.
        fetch_req = 1; fetch_pc = 16'h3002;
        data_req = 1; data_we = 0; data_addr = 16'h4000;
        step();
        check("simul Data_rd first", Data_rd, 1);
        check("simul no fetch yet", instrmem_rd, 0);
        check("simul Data_addr", Data_addr, 16'h4000);
        complete_data = 1; Data_dout = 16'hBEEF;
        step();
        complete_data = 0;
        check("simul data_ack", data_ack, 1);
        check("simul data_rdata", data_rdata, 16'hBEEF);
        step();
        data_req = 0;
        check("simul fetch follows", instrmem_rd, 1);
        check("simul pc", pc, 16'h3002);
        complete_instr = 1; Instr_dout = 16'h5020;
        step();
        complete_instr = 0;
        check("simul fetch_instr", fetch_instr, 16'h5020);
        step();
        fetch_req = 0;
        step();

        // Store with three wait states, completing on the watchdog's last edge.
        data_req = 1; data_we = 1; data_addr = 16'h3050; data_wdata = 16'h00A5;
        step();
        data_wdata = 16'hFFFF; data_addr = 16'h0000;
        cyc = 0;
        for (int i = 0; i < TO; i++) begin
            if (Data_wr) cyc++;
            check("store Data_din stable", Data_din, 16'h00A5);
            check("store Data_addr stable", Data_addr, 16'h3050);
            check("store no early ack", data_ack, 0);
            if (i == TO - 1) complete_data = 1;
            step();
        end
        complete_data = 0;
        check("store Data_wr cycles", cyc, 4);
        check("store data_ack", data_ack, 1);
        check("store no timeout_err", timeout_err, 0);
        check("store keeps data_rdata", data_rdata, 16'hBEEF);
        step();
        data_req = 0; data_we = 0;
        step();

        // Stray completes in IDLE and of the wrong kind during a load.
        complete_instr = 1;
        step();
        complete_instr = 0;
        check("stray idle no ack", fetch_ack, 0);
        check("stray idle busy", busy, 0);
        data_req = 1; data_addr = 16'h4100;
        step();
        complete_instr = 1;
        step();
        complete_instr = 0;
        check("wrong complete no ack", data_ack, 0);
        check("wrong complete Data_rd", Data_rd, 1);
        complete_data = 1; Data_dout = 16'h1357;
        step();
        complete_data = 0;
        check("load after stray ack", data_ack, 1);
        check("load after stray rdata", data_rdata, 16'h1357);
        step();
        data_req = 0;
        step();

        // Fetch that never completes is aborted after TO strobe cycles.
        fetch_req = 1; fetch_pc = 16'h3100;
        step();
        cyc = 0;
        for (int i = 0; i < TO; i++) begin
            if (instrmem_rd) cyc++;
            check("to fetch no early err", timeout_err, 0);
            step();
        end
        check("to fetch strobe cycles", cyc, 4);
        check("to fetch timeout_err", timeout_err, 1);
        check("to fetch fetch_ack", fetch_ack, 1);
        check("to fetch fetch_instr", fetch_instr, 16'h0000);
        check("to fetch strobe dropped", instrmem_rd, 0);
        step();
        fetch_req = 0;
        step();

        // Load that never completes forces data_rdata to zero.
        data_req = 1; data_we = 0; data_addr = 16'h4200;
        for (int i = 0; i <= TO; i++) step();
        check("to load timeout_err", timeout_err, 1);
        check("to load data_ack", data_ack, 1);
        check("to load data_rdata", data_rdata, 16'h0000);
        step();
        data_req = 0;
        step();
        step();

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_master.md
# lc3_mem_master

Memory-side initiator for the LC3 core: arbitrates between the fetch stage and the memory-access stage, drives the instruction- and data-memory request signals (`instrmem_rd`/`pc`, `Data_rd`/`Data_wr`/`Data_addr`/`Data_din`), and holds each request until the memory answers with `complete_instr`/`complete_data`. It returns the fetched instruction or load data to the core with a one-cycle acknowledge. A watchdog aborts any access the memory never completes.

## Interface
- `TIMEOUT`, 255: max cycles an access may wait for complete; 0 disables the watchdog.
- `clk`  in  1  core clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  fetch stage requests instruction at `fetch_pc`; held until `fetch_ack`.
- `fetch_pc`  in  16  instruction address.
- `fetch_ack`  out  1  one-cycle pulse; `fetch_instr` valid this cycle.
- `fetch_instr`  out  16  returned instruction, held until next fetch ack.
- `data_req`  in  1  memory stage requests a data access; held until `data_ack`.
- `data_we`  in  1  1 = store, 0 = load.
- `data_addr`  in  16  data address.
- `data_wdata`  in  16  store data.
- `data_ack`  out  1  one-cycle pulse; load data valid / store done.
- `data_rdata`  out  16  returned load data, held until next load ack.
- `busy`  out  1  high whenever an access is outstanding.
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts an access.
- `instrmem_rd`  out  1  instruction read strobe.
- `pc`  out  16  instruction memory address.
- `Instr_dout`  in  16  instruction from memory.
- `complete_instr`  in  1  instruction memory done.
- `Data_rd`  out  1  data read strobe.
- `Data_wr`  out  1  data write strobe.
- `Data_addr`  out  16  data memory address.
- `Data_din`  out  16  write data to memory.
- `Data_dout`  in  16  read data from memory.
- `complete_data`  in  1  data memory done (reads and writes).

## Operation
- States: IDLE, FETCH, DREAD, DWRITE. All outputs registered.
- Reset (async, any state): state IDLE; every output 0, including `pc`, `Data_addr`, `Data_din`, `fetch_instr`, `data_rdata`; watchdog counter 0.
- IDLE: if `data_req` → DREAD (`data_we`=0) or DWRITE (`data_we`=1); else if `fetch_req` → FETCH. Data has priority over fetch when both are high.
- Entering FETCH: latch `fetch_pc` to `pc`, `instrmem_rd`=1. DREAD: latch `data_addr`, `Data_rd`=1. DWRITE: latch `data_addr`, `data_wdata`, `Data_wr`=1. Address/data stay stable while the strobe is high; later core input changes are ignored.
- FETCH: on an edge with `complete_instr`=1, capture `Instr_dout` into `fetch_instr`, drop `instrmem_rd`, pulse `fetch_ack`, go IDLE.
- DREAD: on `complete_data`=1, capture `Data_dout` into `data_rdata`, drop `Data_rd`, pulse `data_ack`, go IDLE. DWRITE: same, without a data capture, dropping `Data_wr`.
- A complete of the wrong kind (e.g. `complete_instr` in DREAD) or any complete in IDLE is ignored.
- Watchdog: counter clears on entry to each access state and increments each cycle in it. When it reaches `TIMEOUT` with no complete, drop the strobe, pulse `timeout_err` and the matching ack (`fetch_instr`/`data_rdata` forced to 16'h0000 on read aborts), and go IDLE. Complete and timeout on the same edge count as completion; no error.
- `busy` = state != IDLE.

## Timing
- Request sampled in IDLE at edge N. Strobe is high from N+1. Complete sampled at edge M ≥ N+1. Ack high in cycle M..M+1, strobe low from M+1.
- Zero-wait memory (complete high in the first strobe cycle) gives 2-cycle latency from request to ack.
- In an ack cycle, the acknowledged requester's `*_req` is not treated as a new request. The other requester may be accepted in that cycle, so back-to-back accesses take 2 cycles each minimum.
- `Data_rd` and `Data_wr` are never high together. A memory strobe is never high in IDLE.

## Test plan
- Reset mid-access: assert `reset` low while in DREAD with `Data_rd`=1 → all outputs 0 immediately (asynchronous); after release, IDLE with `busy`=0.
- Zero-wait fetch: `fetch_req`=1, `fetch_pc`=16'h3000, memory returns 16'h1261 with `complete_instr` in the first strobe cycle → `pc`=16'h3000, `fetch_ack` 2 cycles after the request, `fetch_instr`=16'h1261.
- Simultaneous requests: `fetch_req`=1 and `data_req`=1 load at 16'h4000 → DREAD first, `data_ack` returns `Data_dout`=16'hBEEF, then FETCH starts in the following IDLE cycle.
- Store with 3 wait cycles: `data_we`=1, addr 16'h3050, wdata 16'h00A5; change `data_wdata` mid-access → `Data_wr`=1 for 4 cycles with `Data_din` stable at 16'h00A5; `data_ack` only after `complete_data`.
- Wrong/stray completes: `complete_instr` pulsed in IDLE and during DREAD → no ack, state unchanged; `complete_data` then completes normally.
- Timeout: `TIMEOUT`=4, fetch with no complete → `instrmem_rd` high 4 cycles, then `timeout_err` and `fetch_ack` pulse together with `fetch_instr`=16'h0000; a complete on the 4th-cycle edge completes normally with no error.
